// File: rtl/hmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// Interfaces used by hmem_arbiter.
//
// memory_if : one request/response port towards a higher memory level.
//   req_valid      requester -> server  request pending (held for the whole
//                                       multi-beat sequence)
//   req_operation  requester -> server  0 = LOAD, 1 = STORE
//   req_address    requester -> server  beat address
//   req_store_data requester -> server  store data for STORE beats
//   req_fulfilled  server -> requester  one-cycle pulse per completed beat
//   req_load_data  server -> requester  load data, valid with req_fulfilled
//
// reset_if  : carries the synchronous, active-high system reset.
// ---------------------------------------------------------------------------
interface memory_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_operation;
  logic [ADDR_W-1:0] req_address;
  logic [DATA_W-1:0] req_store_data;
  logic              req_fulfilled;
  logic [DATA_W-1:0] req_load_data;

  modport requester (
    output req_valid, req_operation, req_address, req_store_data,
    input  req_fulfilled, req_load_data
  );

  modport server (
    input  req_valid, req_operation, req_address, req_store_data,
    output req_fulfilled, req_load_data
  );
endinterface

interface reset_if;
  logic reset;

  modport sink   (input  reset);
  modport source (output reset);
endinterface

// File: rtl/hmem_arbiter.sv
// ---------------------------------------------------------------------------
// hmem_arbiter
//
// Shares one next-level memory port between the I-cache and D-cache
// controllers. A requester keeps req_valid high for its whole miss-recovery
// sequence (writeback + allocate, or flush); the arbiter hands it the port
// for that entire sequence and never interleaves beats from two requesters.
// Simultaneous requests are resolved round-robin.
//
// Ports:
//   clk          system clock, all state changes on posedge
//   rst_if       reset_if.sink, rst_if.reset is synchronous active-high
//   icache_if    memory_if.server, requester 0 (I-cache hmem side)
//   dcache_if    memory_if.server, requester 1 (D-cache hmem side)
//   mem_if       memory_if.requester, shared port to the next memory level
//   grant_owner  one-hot owner (bit0 = I, bit1 = D, 00 = none), registered
//
// Optional statistics (macro HMEM_ARB_STATS_EN): adds the saturating
// STAT_W-wide counters icache_grants, dcache_grants, icache_wait_cycles,
// dcache_wait_cycles. With the macro undefined the counters do not exist
// and arbitration is unchanged.
// ---------------------------------------------------------------------------
module hmem_arbiter #(
  parameter int STAT_W = 32
) (
  input  logic        clk,
  reset_if.sink       rst_if,
  memory_if.server    icache_if,
  memory_if.server    dcache_if,
  memory_if.requester mem_if,
  output logic [1:0]  grant_owner
`ifdef HMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] icache_grants,
  output logic [STAT_W-1:0] dcache_grants,
  output logic [STAT_W-1:0] icache_wait_cycles,
  output logic [STAT_W-1:0] dcache_wait_cycles
`endif
);

  localparam logic OP_LOAD = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } state_t;

  state_t     state_reg;
  logic       last_grant_reg;   // 0 = I-cache was last owner, 1 = D-cache
  logic [1:0] grant_owner_reg;

  logic [1:0] req_valid;
  logic       take_i;
  logic       take_d;

  assign req_valid = {dcache_if.req_valid, icache_if.req_valid};

  // A requester takes the port either from idle (alone, or by winning the
  // round-robin tie) or directly from the other requester on the cycle the
  // other one drops req_valid, which avoids an idle bubble between owners.
  // Both terms are mutually exclusive because of the last_grant tie-break.
  assign take_i = req_valid[0] &&
                  (((state_reg == ST_IDLE) && (!req_valid[1] || last_grant_reg)) ||
                   ((state_reg == ST_GRANT_D) && !req_valid[1]));
  assign take_d = req_valid[1] &&
                  (((state_reg == ST_IDLE) && (!req_valid[0] || !last_grant_reg)) ||
                   ((state_reg == ST_GRANT_I) && !req_valid[0]));

  // ------------------------------------------------------------------------
  // Ownership FSM with registered grant_owner
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_if.reset) begin
      state_reg       <= ST_IDLE;
      last_grant_reg  <= 1'b0;       // I counts as last, so D wins the first tie
      grant_owner_reg <= 2'b00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (take_i) begin
            state_reg       <= ST_GRANT_I;
            grant_owner_reg <= 2'b01;
          end else if (take_d) begin
            state_reg       <= ST_GRANT_D;
            grant_owner_reg <= 2'b10;
          end
        end
        ST_GRANT_I: begin
          // No preemption: only the owner releasing ends the grant.
          if (!req_valid[0]) begin
            last_grant_reg <= 1'b0;
            if (take_d) begin
              state_reg       <= ST_GRANT_D;
              grant_owner_reg <= 2'b10;
            end else begin
              state_reg       <= ST_IDLE;
              grant_owner_reg <= 2'b00;
            end
          end
        end
        ST_GRANT_D: begin
          if (!req_valid[1]) begin
            last_grant_reg <= 1'b1;
            if (take_i) begin
              state_reg       <= ST_GRANT_I;
              grant_owner_reg <= 2'b01;
            end else begin
              state_reg       <= ST_IDLE;
              grant_owner_reg <= 2'b00;
            end
          end
        end
        default: begin
          state_reg       <= ST_IDLE;
          grant_owner_reg <= 2'b00;
        end
      endcase
    end
  end

  assign grant_owner = grant_owner_reg;

  // ------------------------------------------------------------------------
  // Request/response steering. The owner's request is forwarded
  // combinationally so an owner that drops req_valid takes mem_if.req_valid
  // down in the same cycle. Load data fans out to both; only the owner sees
  // req_fulfilled, so the non-owner ignores it.
  // ------------------------------------------------------------------------
  assign icache_if.req_load_data = mem_if.req_load_data;
  assign dcache_if.req_load_data = mem_if.req_load_data;

  always_comb begin
    mem_if.req_valid         = 1'b0;
    mem_if.req_operation     = OP_LOAD;
    mem_if.req_address       = '0;
    mem_if.req_store_data    = '0;
    icache_if.req_fulfilled  = 1'b0;
    dcache_if.req_fulfilled  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
      end
      ST_GRANT_I: begin
        mem_if.req_valid        = icache_if.req_valid;
        mem_if.req_operation    = icache_if.req_operation;
        mem_if.req_address      = icache_if.req_address;
        mem_if.req_store_data   = icache_if.req_store_data;
        icache_if.req_fulfilled = icache_if.req_valid & mem_if.req_fulfilled;
      end
      ST_GRANT_D: begin
        mem_if.req_valid        = dcache_if.req_valid;
        mem_if.req_operation    = dcache_if.req_operation;
        mem_if.req_address      = dcache_if.req_address;
        mem_if.req_store_data   = dcache_if.req_store_data;
        dcache_if.req_fulfilled = dcache_if.req_valid & mem_if.req_fulfilled;
      end
      default: begin
        mem_if.req_valid        = 1'bx;
        mem_if.req_operation    = 1'bx;
        mem_if.req_address      = 'x;
        mem_if.req_store_data   = 'x;
        icache_if.req_fulfilled = 1'bx;
        dcache_if.req_fulfilled = 1'bx;
      end
    endcase
  end

`ifdef HMEM_ARB_STATS_EN
  // ------------------------------------------------------------------------
  // Saturating statistics, one counter pair per requester (0 = I, 1 = D).
  // Waiting includes the idle arbitration cycle, since the requester is
  // valid there but not yet the owner.
  // ------------------------------------------------------------------------
  logic [1:0] take;
  assign take = {take_d, take_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stats
    logic [STAT_W-1:0] grants_reg;
    logic [STAT_W-1:0] wait_reg;

    always_ff @(posedge clk) begin
      if (rst_if.reset) begin
        grants_reg <= '0;
        wait_reg   <= '0;
      end else begin
        if (take[gi] && (grants_reg != '1))
          grants_reg <= grants_reg + STAT_W'(1);
        if (req_valid[gi] && !grant_owner_reg[gi] && (wait_reg != '1))
          wait_reg <= wait_reg + STAT_W'(1);
      end
    end
  end

  assign icache_grants      = g_stats[0].grants_reg;
  assign dcache_grants      = g_stats[1].grants_reg;
  assign icache_wait_cycles = g_stats[0].wait_reg;
  assign dcache_wait_cycles = g_stats[1].wait_reg;
`endif

endmodule

// File: tb/tb_hmem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for hmem_arbiter: a vector table for the basic ownership rules,
// hand-written multi-cycle sequences, and a randomized run compared with a
// behavioural ownership model. Statistics are checked when HMEM_ARB_STATS_EN
// is defined (counters built 4 bits wide so saturation is reachable).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hmem_arbiter;

  localparam int   TB_STAT_W = 4;
  localparam int   SAT_MAX   = (1 << TB_STAT_W) - 1;
  localparam logic LOAD      = 1'b0;
  localparam logic STORE     = 1'b1;
  localparam logic [31:0] I_ADDR = 32'h1000_0040;
  localparam logic [31:0] D_ADDR = 32'h2000_0080;
  localparam logic [31:0] I_DATA = 32'hAAAA_1111;
  localparam logic [31:0] D_DATA = 32'h5555_2222;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  reset_if  rst_if ();
  memory_if icache_if ();
  memory_if dcache_if ();
  memory_if mem_if ();
  logic [1:0] grant_owner;
`ifdef HMEM_ARB_STATS_EN
  logic [TB_STAT_W-1:0] icache_grants, dcache_grants;
  logic [TB_STAT_W-1:0] icache_wait_cycles, dcache_wait_cycles;
`endif

  hmem_arbiter #(.STAT_W(TB_STAT_W)) dut (
    .clk                (clk),
    .rst_if             (rst_if),
    .icache_if          (icache_if),
    .dcache_if          (dcache_if),
    .mem_if             (mem_if),
    .grant_owner        (grant_owner)
`ifdef HMEM_ARB_STATS_EN
    ,
    .icache_grants      (icache_grants),
    .dcache_grants      (dcache_grants),
    .icache_wait_cycles (icache_wait_cycles),
    .dcache_wait_cycles (dcache_wait_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic vi, input logic vd, input logic oi,
                         input logic od, input logic ful);
    icache_if.req_valid     = vi;
    icache_if.req_operation = oi;
    dcache_if.req_valid     = vd;
    dcache_if.req_operation = od;
    mem_if.req_fulfilled    = ful;
    #1;
  endtask

  task automatic do_reset();
    rst_if.reset = 1'b1;
    icache_if.req_address    = I_ADDR;
    icache_if.req_store_data = I_DATA;
    dcache_if.req_address    = D_ADDR;
    dcache_if.req_store_data = D_DATA;
    mem_if.req_load_data     = 32'hC0DE_0001;
    set_req(1'b0, 1'b0, LOAD, LOAD, 1'b0);
    repeat (2) tick();
    rst_if.reset = 1'b0;
  endtask

  // ------------------------------------------------------------------------
  // Vector table: one row per cycle, starting right after reset.
  // ------------------------------------------------------------------------
  typedef struct {
    logic       vi, vd, oi, od, ful;
    logic [1:0] go;
    logic       mv, mop, fi, fd;
  } vec_t;

  vec_t vecs [13];

  // ------------------------------------------------------------------------
  // Reference model: who owns the port, who won last, and the statistics.
  // ------------------------------------------------------------------------
  int   m_owner;       // -1 none, 0 I-cache, 1 D-cache
  int   m_last;
  int   m_grants [2];
  int   m_wait   [2];
  logic rv  [2];
  logic rop [2];

  function automatic int sat_inc(input int v);
    return (v >= SAT_MAX) ? SAT_MAX : v + 1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    for (int x = 0; x < 2; x++) begin
      m_grants[x] = 0;
      m_wait[x]   = 0;
    end
  endtask

  // Advance the model by one clock given this cycle's request lines.
  task automatic model_step();
    int first;
    int nxt;
    for (int x = 0; x < 2; x++)
      if (rv[x] && m_owner != x) m_wait[x] = sat_inc(m_wait[x]);
    if (m_owner >= 0 && rv[m_owner]) return;
    if (m_owner >= 0) m_last = m_owner;
    // The requester that did not win last has priority.
    first = 1 - m_last;
    if (rv[first])          nxt = first;
    else if (rv[1 - first]) nxt = 1 - first;
    else                    nxt = -1;
    if (nxt >= 0) begin
      m_grants[nxt] = sat_inc(m_grants[nxt]);
      $display("random: grant -> %s", (nxt == 0) ? "I-cache" : "D-cache");
    end
    m_owner = nxt;
  endtask

  initial begin : watchdog
    #200_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [1:0] owner;
    int         beats;
    logic       owner_valid;
    logic [1:0] exp_go;
    logic       exp_fi, exp_fd;

    //        vi    vd    oi    od    ful   go     mv    mop   fi    fd
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0};

    // ---------------- reset state + vector table ----------------
    do_reset();
    chk("reset grant_owner", grant_owner, 2'b00);
    chk("reset mem valid", mem_if.req_valid, 1'b0);
    chk("reset mem op", mem_if.req_operation, LOAD);
    chk("reset i fulfilled", icache_if.req_fulfilled, 1'b0);
    chk("reset d fulfilled", dcache_if.req_fulfilled, 1'b0);
`ifdef HMEM_ARB_STATS_EN
    chk("reset stats", {icache_grants, dcache_grants, icache_wait_cycles, dcache_wait_cycles}, '0);
`endif
    for (int i = 0; i < 13; i++) begin
      if (i > 0) tick();
      set_req(vecs[i].vi, vecs[i].vd, vecs[i].oi, vecs[i].od, vecs[i].ful);
      $display("vec %0d: vi=%b vd=%b ful=%b -> owner=%b mem_valid=%b",
               i, vecs[i].vi, vecs[i].vd, vecs[i].ful, grant_owner, mem_if.req_valid);
      chk($sformatf("vec%0d owner", i), grant_owner, vecs[i].go);
      chk($sformatf("vec%0d mem valid", i), mem_if.req_valid, vecs[i].mv);
      chk($sformatf("vec%0d mem op", i), mem_if.req_operation, vecs[i].mop);
      chk($sformatf("vec%0d i ful", i), icache_if.req_fulfilled, vecs[i].fi);
      chk($sformatf("vec%0d d ful", i), dcache_if.req_fulfilled, vecs[i].fd);
      if (vecs[i].mv)
        chk($sformatf("vec%0d mem addr", i), mem_if.req_address,
            (vecs[i].go == 2'b01) ? I_ADDR : D_ADDR);
    end

    // ---------------- single I request, 4 LOAD beats ----------------
    do_reset();
    set_req(1'b1, 1'b0, LOAD, LOAD, 1'b0);
    chk("single arb cycle owner", grant_owner, 2'b00);
    beats = 0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      tick();
      set_req(1'b1, 1'b0, LOAD, LOAD, c[0]);
      chk("single owner", grant_owner, 2'b01);
      chk("single mem valid", mem_if.req_valid, 1'b1);
      chk("single i ful", icache_if.req_fulfilled, c[0]);
      chk("single d ful", dcache_if.req_fulfilled, 1'b0);
      if (icache_if.req_fulfilled === 1'b1) beats++;
    end
    chk("single beat count", beats, 4);
    tick();
    set_req(1'b0, 1'b0, LOAD, LOAD, 1'b0);
    chk("single drop mem valid", mem_if.req_valid, 1'b0);
    tick();
    chk("single back to idle", grant_owner, 2'b00);
    $display("single I transfer: %0d beats", beats);

    // ---------------- writeback then allocate on D, I waiting ----------------
    do_reset();
    set_req(1'b1, 1'b1, LOAD, STORE, 1'b0);
    chk("wb arb owner", grant_owner, 2'b00);
    for (int b = 0; b < 8; b++) begin
      tick();
      set_req(1'b1, 1'b1, LOAD, (b < 4) ? STORE : LOAD, 1'b1);
      chk($sformatf("wb beat%0d owner", b), grant_owner, 2'b10);
      chk($sformatf("wb beat%0d op", b), mem_if.req_operation, (b < 4) ? STORE : LOAD);
      chk($sformatf("wb beat%0d d ful", b), dcache_if.req_fulfilled, 1'b1);
      chk($sformatf("wb beat%0d i ful", b), icache_if.req_fulfilled, 1'b0);
    end
    tick();
    set_req(1'b1, 1'b0, LOAD, LOAD, 1'b0);
    chk("wb drop mem valid", mem_if.req_valid, 1'b0);
    chk("wb drop owner", grant_owner, 2'b10);
    tick();
    chk("wb handoff owner", grant_owner, 2'b01);
    chk("wb handoff mem valid", mem_if.req_valid, 1'b1);
`ifdef HMEM_ARB_STATS_EN
    chk("wb i wait cycles", icache_wait_cycles, 4'd10);
    chk("wb grants", {icache_grants, dcache_grants}, {4'd1, 4'd1});
`endif
    $display("writeback+allocate: D held 8 beats, then I granted");

    // ---------------- round-robin alternation ----------------
    do_reset();
    set_req(1'b1, 1'b1, LOAD, LOAD, 1'b0);
    for (int t = 0; t < 6; t++) begin
      for (int w = 0; w < 5 && grant_owner == 2'b00; w++) tick();
      owner = grant_owner;
      $display("round-robin txn %0d: owner=%b", t, owner);
      chk($sformatf("rr order %0d", t), owner, (t % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      set_req(owner != 2'b01, owner != 2'b10, LOAD, LOAD, 1'b0);
      tick();
      set_req(1'b1, 1'b1, LOAD, LOAD, 1'b0);
    end

    // ---------------- reset during an I transfer ----------------
    do_reset();
    set_req(1'b1, 1'b0, LOAD, LOAD, 1'b0);
    tick();
    set_req(1'b1, 1'b0, LOAD, LOAD, 1'b1);
    chk("rst beat1 owner", grant_owner, 2'b01);
    tick();
    rst_if.reset = 1'b1;
    set_req(1'b1, 1'b0, LOAD, LOAD, 1'b1);
    tick();
    rst_if.reset = 1'b0;
    set_req(1'b1, 1'b1, LOAD, LOAD, 1'b0);
    chk("rst owner cleared", grant_owner, 2'b00);
    chk("rst mem valid", mem_if.req_valid, 1'b0);
    tick();
    chk("rst tie to D", grant_owner, 2'b10);
    $display("reset mid-transfer: owner after recovery=%b", grant_owner);

    // ---------------- randomized run against the model ----------------
    do_reset();
    model_reset();
    rv[0] = 1'b0; rv[1] = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (n > 0) tick();
      for (int x = 0; x < 2; x++) begin
        rv[x] = rv[x] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 3) == 0) rop[x] = $urandom_range(0, 1) == 1;
      end
      icache_if.req_address    = $urandom;
      icache_if.req_store_data = $urandom;
      dcache_if.req_address    = $urandom;
      dcache_if.req_store_data = $urandom;
      mem_if.req_load_data     = $urandom;
      set_req(rv[0], rv[1], rop[0], rop[1], $urandom_range(0, 1) == 1);

      owner_valid = (m_owner >= 0) ? rv[m_owner] : 1'b0;
      exp_go = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
      exp_fi = (m_owner == 0) && rv[0] && mem_if.req_fulfilled;
      exp_fd = (m_owner == 1) && rv[1] && mem_if.req_fulfilled;
      chk($sformatf("rnd%0d owner", n), grant_owner, exp_go);
      chk($sformatf("rnd%0d mem valid", n), mem_if.req_valid, owner_valid);
      chk($sformatf("rnd%0d i ful", n), icache_if.req_fulfilled, exp_fi);
      chk($sformatf("rnd%0d d ful", n), dcache_if.req_fulfilled, exp_fd);
      if (owner_valid) begin
        chk($sformatf("rnd%0d mem op", n), mem_if.req_operation, rop[m_owner]);
        chk($sformatf("rnd%0d mem addr", n), mem_if.req_address,
            (m_owner == 0) ? icache_if.req_address : dcache_if.req_address);
        chk($sformatf("rnd%0d mem wdata", n), mem_if.req_store_data,
            (m_owner == 0) ? icache_if.req_store_data : dcache_if.req_store_data);
        chk($sformatf("rnd%0d load data", n),
            (m_owner == 0) ? icache_if.req_load_data : dcache_if.req_load_data,
            mem_if.req_load_data);
      end
      model_step();
    end
    tick();
`ifdef HMEM_ARB_STATS_EN
    chk("rnd i grants", icache_grants, m_grants[0]);
    chk("rnd d grants", dcache_grants, m_grants[1]);
    chk("rnd i wait", icache_wait_cycles, m_wait[0]);
    chk("rnd d wait", dcache_wait_cycles, m_wait[1]);

    // ---------------- grant counter saturation ----------------
    do_reset();
    for (int g = 0; g < 20; g++) begin
      set_req(1'b0, 1'b1, LOAD, LOAD, 1'b0);
      tick();
      set_req(1'b0, 1'b0, LOAD, LOAD, 1'b0);
      tick();
    end
    chk("sat d grants", dcache_grants, 4'd15);
    chk("sat i grants", icache_grants, 4'd0);
    $display("saturation: dcache_grants=%0d after 20 grants", dcache_grants);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hmem_arbiter.md
Name: hmem_arbiter

Overview:
- Shares one higher-level memory port between the instruction-cache and data-cache controllers.
- Each cache controller holds req_valid high for the whole miss-recovery sequence (writeback + allocate, or flush). The arbiter grants the port to one requester for that entire sequence and never interleaves beats from two requesters.
- Sits between the two L1 cache controllers' hmem_if ports and the next memory level.
- Ties between simultaneous requesters are broken round-robin.

Parameters:
- STAT_W, 32, width of the statistics counters (only used when HMEM_ARB_STATS_EN is defined).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_if  reset_if  1  rst_if.reset: synchronous, active-high reset.
- icache_if  memory_if.server  bundle  requester 0 (I-cache controller's hmem side).
- dcache_if  memory_if.server  bundle  requester 1 (D-cache controller's hmem side).
- mem_if  memory_if.requester  bundle  shared port to the next memory level.
- grant_owner  output  2  one-hot current owner: bit0 = I-cache, bit1 = D-cache; 00 = none.
- Stats ports: see Optional Feature.

Behaviour:
- One clock (clk). Reset is synchronous and active-high on rst_if.reset.
- State register: ST_IDLE, ST_GRANT_I, ST_GRANT_D; encoding is free. Illegal state drives outputs to X in simulation.
- last_grant register: 1 bit, 0 = I, 1 = D.
- Reset values:
  - state = ST_IDLE; last_grant = I (so the D-cache wins the first tie).
  - grant_owner = 00; mem_if.req_valid = 0; mem_if.req_operation = LOAD.
  - icache_if.req_fulfilled = 0; dcache_if.req_fulfilled = 0.
- ST_IDLE:
  - Outputs: mem_if.req_valid = 0 and both req_fulfilled = 0.
  - Only I valid -> ST_GRANT_I.
  - Only D valid -> ST_GRANT_D.
  - Both valid -> grant the requester that is not last_grant.
  - Neither valid -> stay in ST_IDLE.
- Arbitration latency: exactly 1 cycle from first req_valid in ST_IDLE to the owner's request appearing on mem_if.
- ST_GRANT_x, owner still valid:
  - mem_if.req_valid, req_operation and all address/store-data fields are combinational copies of the owner's.
  - Owner's req_fulfilled and load data are combinational copies from mem_if.
  - Non-owner's req_fulfilled = 0 and its load data is don't-care.
- ST_GRANT_x, owner drops req_valid:
  - mem_if.req_valid = 0 that same cycle.
  - last_grant <= owner.
  - If the other requester is valid that cycle -> go directly to its grant state (no idle bubble). Otherwise -> ST_IDLE.
- No preemption: a grant is held while the owner's req_valid stays high, regardless of the other requester.
- Multi-beat transfers: mem_if.req_fulfilled pulses pass straight through to the owner. The arbiter keeps no beat counter; the owner's controller counts beats.
- Owner operation change (STORE beats of writeback followed by LOAD beats of allocate, req_valid continuously high): forwarded without re-arbitration.
- Non-owner asserting req_valid: that requester simply waits; no side effects.
- Reset mid-transfer: state returns to ST_IDLE next edge and mem_if.req_valid drops. Memory-side recovery is out of scope.
- grant_owner: 01 in ST_GRANT_I, 10 in ST_GRANT_D, 00 in ST_IDLE; a Moore output.

Optional Feature:
- Macro: HMEM_ARB_STATS_EN.
- When defined, adds these outputs, each STAT_W wide:
  - icache_grants: increments on each entry to ST_GRANT_I.
  - dcache_grants: increments on each entry to ST_GRANT_D.
  - icache_wait_cycles: increments each cycle I is valid but is not the owner, including the ST_IDLE arbitration cycle.
  - dcache_wait_cycles: same rule for D.
- Counter rules: all reset to 0; saturate at all-ones; no wrap.
- When not defined, these ports and their logic do not exist and the arbitration behaviour is identical.

Test Plan:
- Single I request: icache req_valid high with 4-beat LOAD, mem fulfilled every other cycle -> grant_owner = 01 one cycle later; exactly 4 fulfilled pulses reach icache; dcache fulfilled stays 0; ST_IDLE after valid drops.
- Simultaneous first requests after reset: both valid in the same cycle -> D granted first (grant_owner = 10). When D drops valid, I is granted the next cycle with no ST_IDLE cycle in between.
- Writeback then allocate: D holds valid through 4 STORE beats then 4 LOAD beats while I is also valid -> mem_if.req_operation shows STORE x4 then LOAD x4; grant_owner stays 10 throughout; I is granted only after D drops valid.
- Round-robin alternation: both requesters re-request continuously for 6 transactions -> grant order D, I, D, I, D, I.
- Reset mid-transfer: assert rst_if.reset during beat 2 of an I transfer -> next cycle grant_owner = 00, mem_if.req_valid = 0; after reset deasserts, a simultaneous request is granted to D.
- With HMEM_ARB_STATS_EN and STAT_W = 4: force 20 D grants -> dcache_grants = 15 (saturated). The contention scenario above yields icache_wait_cycles equal to the number of cycles I was valid without owning the port.
